// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED brightness sequencer:
//   - LED_LVL_W / LED_LVL_MAX : level and dutycycle width and full-scale value
//   - led_state_e             : breathe-profile sequencer states
//   - led_sat_add / led_sat_sub : clamped level arithmetic used by the ramps
// ---------------------------------------------------------------------------
package led_pkg;

    localparam int LED_LVL_W = 11;
    localparam logic [LED_LVL_W-1:0] LED_LVL_MAX = 11'h7FF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HI   = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LO   = 3'd4
    } led_state_e;

    // Level + step evaluated one bit wider, then clamped to full scale.
    function automatic logic [LED_LVL_W-1:0] led_sat_add(
        input logic [LED_LVL_W-1:0] lvl,
        input logic [7:0]           inc
    );
        logic [LED_LVL_W:0] sum;
        sum = {1'b0, lvl} + {{(LED_LVL_W - 7){1'b0}}, inc};
        return sum[LED_LVL_W] ? LED_LVL_MAX : sum[LED_LVL_W-1:0];
    endfunction

    // Level - step, floored at zero instead of wrapping.
    function automatic logic [LED_LVL_W-1:0] led_sat_sub(
        input logic [LED_LVL_W-1:0] lvl,
        input logic [7:0]           dec
    );
        logic [LED_LVL_W-1:0] dec_ext;
        dec_ext = {{(LED_LVL_W - 8){1'b0}}, dec};
        return (lvl > dec_ext) ? (lvl - dec_ext) : '0;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// ---------------------------------------------------------------------------
// led_tick_gen
// Fade-tick prescaler. Counts 0..TICK_DIV-1 while enabled and is held at 0
// while disabled, so the first tick lands exactly TICK_DIV cycles after the
// enable rises.
// Ports:
//   clk      in  clock
//   rst      in  synchronous reset, active-high (clears the count)
//   en_i     in  count enable (sequencer busy)
//   tick_o   out one-cycle pulse when the count reaches TICK_DIV-1
// ---------------------------------------------------------------------------
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/led_fade_ctrl.sv
// ---------------------------------------------------------------------------
// led_fade_ctrl
// Breathe-profile brightness sequencer driving the LED pwm stage:
// ramp up -> hold bright -> ramp down -> hold dark, repeating until stopped.
// The pwm output is high while its counter >= dutycycle, so this block drives
// dutycycle = 2047 - map(level): a falling dutycycle means a brighter LED.
//
// Build option: LED_FADE_GAMMA_EN
//   defined   : map(l) = (l*l) >> 11 (perceptual fade); the squaring is
//               registered so dutycycle trails level by two cycles.
//   undefined : map(l) = l (linear fade); dutycycle trails level by one cycle.
//   Sequencer, level, busy and cycle_done timing are the same in both builds.
//
// Ports:
//   clk         in   clock
//   rst         in   synchronous reset, active-high; aborts any sequence
//   start       in   1-cycle pulse, accepted only in IDLE
//   stop        in   1-cycle pulse, graceful stop at the end of the period
//   step[7:0]   in   level increment per tick (0 behaves as 1), latched on start
//   hold_ticks  in   extra ticks in each hold state, latched on start
//   busy        out  high in every state except IDLE
//   level       out  current linear brightness (0 dark .. 2047 full)
//   pwm_en      out  pwm enable, identical to busy
//   dutycycle   out  pwm dutycycle
//   cycle_done  out  1-cycle pulse when HOLD_LO finishes
// ---------------------------------------------------------------------------
module led_fade_ctrl
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000,
    parameter int          LVL_W    = LED_LVL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       step,
    input  logic [7:0]       hold_ticks,
    output logic             busy,
    output logic [LVL_W-1:0] level,
    output logic             pwm_en,
    output logic [LVL_W-1:0] dutycycle,
    output logic             cycle_done
);

    led_state_e       state_q;
    logic [LVL_W-1:0] level_q;
    logic [7:0]       hcnt_q;
    logic [7:0]       step_q;
    logic [7:0]       hold_q;
    logic             stop_pend_q;
    logic             busy_q;
    logic             pwm_en_q;
    logic             cycle_done_q;
    logic [LVL_W-1:0] duty_q;

    logic             tick;
    logic [LVL_W-1:0] level_up_d;
    logic [LVL_W-1:0] level_dn_d;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .en_i   (busy_q),
        .tick_o (tick)
    );

    assign level_up_d = led_sat_add(level_q, step_q);
    assign level_dn_d = led_sat_sub(level_q, step_q);

    // Sequencer. Apart from leaving IDLE, every transition waits for a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            level_q      <= '0;
            hcnt_q       <= '0;
            step_q       <= 8'd1;
            hold_q       <= '0;
            stop_pend_q  <= 1'b0;
            busy_q       <= 1'b0;
            pwm_en_q     <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            cycle_done_q <= 1'b0;
            if (stop && (state_q != IDLE)) begin
                stop_pend_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RAMP_UP;
                        level_q     <= '0;
                        step_q      <= (step == 8'd0) ? 8'd1 : step;
                        hold_q      <= hold_ticks;
                        // A stop arriving with the start limits the run to one period.
                        stop_pend_q <= stop;
                        busy_q      <= 1'b1;
                        pwm_en_q    <= 1'b1;
                    end
                end

                RAMP_UP: begin
                    if (tick) begin
                        level_q <= level_up_d;
                        if (level_up_d == LED_LVL_MAX) begin
                            state_q <= HOLD_HI;
                            hcnt_q  <= hold_q;
                        end
                    end
                end

                HOLD_HI: begin
                    if (tick) begin
                        if (hcnt_q == 8'd0) begin
                            state_q <= RAMP_DOWN;
                        end else begin
                            hcnt_q <= hcnt_q - 8'd1;
                        end
                    end
                end

                RAMP_DOWN: begin
                    if (tick) begin
                        level_q <= level_dn_d;
                        if (level_dn_d == '0) begin
                            state_q <= HOLD_LO;
                            hcnt_q  <= hold_q;
                        end
                    end
                end

                HOLD_LO: begin
                    if (tick) begin
                        if (hcnt_q == 8'd0) begin
                            cycle_done_q <= 1'b1;
                            // A stop landing on the final tick still ends this period.
                            if (stop_pend_q || stop) begin
                                state_q     <= IDLE;
                                stop_pend_q <= 1'b0;
                                busy_q      <= 1'b0;
                                pwm_en_q    <= 1'b0;
                            end else begin
                                state_q <= RAMP_UP;
                            end
                        end else begin
                            hcnt_q <= hcnt_q - 8'd1;
                        end
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    level_q     <= '0;
                    stop_pend_q <= 1'b0;
                    busy_q      <= 1'b0;
                    pwm_en_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef LED_FADE_GAMMA_EN
    // Square the level and keep bits [21:11]; the product is registered
    // before the dutycycle subtraction, giving a two-cycle lag.
    logic [2*LVL_W-1:0] sq_full;
    logic [LVL_W-1:0]   map_d;
    logic [LVL_W-1:0]   map_q;

    assign sq_full = {{LVL_W{1'b0}}, level_q} * {{LVL_W{1'b0}}, level_q};
    assign map_d   = LVL_W'(sq_full >> LVL_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            map_q  <= '0;
            duty_q <= LED_LVL_MAX;
        end else begin
            map_q  <= map_d;
            duty_q <= LED_LVL_MAX - map_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= LED_LVL_MAX;
        end else begin
            duty_q <= LED_LVL_MAX - level_q;
        end
    end
`endif

    assign busy       = busy_q;
    assign pwm_en     = pwm_en_q;
    assign level      = level_q;
    assign dutycycle  = duty_q;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_fade_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_fade_ctrl
// Scoreboard bench for led_fade_ctrl with TICK_DIV = 4. Stimulus pushes the
// expected sequence of output changes (level, busy, cycle_done and the number
// of cycles since the previous change) into a queue; a monitor pops one entry
// each time any of those outputs changes. The monitor also tracks the
// dutycycle against the level history every cycle. Compile with
// LED_FADE_GAMMA_EN defined to exercise the gamma build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_fade_ctrl;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  step = 8'd0;
    logic [7:0]  hold_ticks = 8'd0;
    logic        busy;
    logic [10:0] level;
    logic        pwm_en;
    logic [10:0] dutycycle;
    logic        cycle_done;

    led_fade_ctrl #(
        .TICK_DIV (TD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .hold_ticks (hold_ticks),
        .busy       (busy),
        .level      (level),
        .pwm_en     (pwm_en),
        .dutycycle  (dutycycle),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lvl;
        bit bsy;
        bit cd;
        int gap;   // cycles since previous change; 0 = not checked
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;

    // Saturation scenario (step 200, hold 1), worked out by hand.
    int b_lv[22] = '{200, 400, 600, 800, 1000, 1200, 1400, 1600, 1800, 2000, 2047,
                     1847, 1647, 1447, 1247, 1047, 847, 647, 447, 247, 47, 0};

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t",
                     name, act, act, req, req, $time);
        end
    endfunction

    task automatic push(int l, bit b, bit c, int g);
        ev_t e;
        e.lvl = l; e.bsy = b; e.cd = c; e.gap = g;
        exp_q.push_back(e);
    endtask

    // Expected changes for one full period starting from level 0.
    task automatic push_period(int s_in, int hold, bit last, bit after_restart);
        int  s;
        int  lvl;
        bit  first;
        s = (s_in == 0) ? 1 : s_in;
        lvl = 0;
        first = 1'b1;
        while (lvl != 2047) begin
            lvl = (lvl + s > 2047) ? 2047 : lvl + s;
            push(lvl, 1'b1, 1'b0, first ? (after_restart ? TD - 1 : TD) : TD);
            first = 1'b0;
        end
        first = 1'b1;
        while (lvl != 0) begin
            lvl = (lvl >= s) ? lvl - s : 0;
            push(lvl, 1'b1, 1'b0, first ? TD * (hold + 2) : TD);
            first = 1'b0;
        end
        push(0, !last, 1'b1, TD * (hold + 1));
        push(0, !last, 1'b0, 1);
    endtask

    // Monitor: one scoreboard pop per output change, plus per-cycle dutycycle.
    initial begin
        int  prev_l;
        bit  prev_b;
        bit  prev_c;
        int  h1;
        int  h2;
        int  since;
        int  exp_d;
        ev_t e;
        prev_l = 0; prev_b = 0; prev_c = 0; h1 = 0; h2 = 0; since = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_l = 0; prev_b = 0; prev_c = 0; h1 = 0; h2 = 0; since = 0;
            end else begin
                since++;
                if ((int'(level) != prev_l) || (busy != prev_b) || (cycle_done != prev_c)) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_change: got level=%0d busy=%0b cycle_done=%0b, required no change at %0t",
                                 level, busy, cycle_done, $time);
                    end else begin
                        e = exp_q.pop_front();
                        $display("ev level=%0d busy=%0b cycle_done=%0b gap=%0d (req level=%0d busy=%0b cd=%0b gap=%0d)",
                                 level, busy, cycle_done, since, e.lvl, e.bsy, e.cd, e.gap);
                        check("level", int'(level), e.lvl);
                        check("busy", int'(busy), int'(e.bsy));
                        check("cycle_done", int'(cycle_done), int'(e.cd));
                        if (e.gap != 0) check("gap", since, e.gap);
                    end
                    since = 0;
                end
                check("pwm_en_eq_busy", int'(pwm_en), int'(busy));
`ifdef LED_FADE_GAMMA_EN
                exp_d = 2047 - ((h2 * h2) >> 11);
                if (h2 == 1024) check("duty_at_1024", int'(dutycycle), 'h5FF);
`else
                exp_d = 2047 - h1;
                if (h1 == 1024) check("duty_at_1024", int'(dutycycle), 'h3FF);
`endif
                check("dutycycle", int'(dutycycle), exp_d);
                h2 = h1;
                h1 = int'(level);
                prev_l = int'(level);
                prev_b = busy;
                prev_c = cycle_done;
            end
        end
    end

    task automatic do_start(int s, int h, bit with_stop);
        @(negedge clk);
        step = 8'(s);
        hold_ticks = 8'(h);
        start = 1'b1;
        stop = with_stop;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic wait_drain(int limit, string name);
        int c;
        c = 0;
        while ((exp_q.size() != 0) && (c < limit)) begin
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d changes still pending after %0d cycles, required 0",
                     name, exp_q.size(), c);
            exp_q.delete();
        end
    endtask

    task automatic wait_cd(int limit);
        int c;
        c = 0;
        while ((cycle_done !== 1'b1) && (c < limit)) begin
            @(negedge clk);
            c++;
        end
        check("cycle_done_seen", int'(cycle_done === 1'b1), 1);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_pwm_en"}, int'(pwm_en), 0);
        check({tag, "_level"}, int'(level), 0);
        check({tag, "_dutycycle"}, int'(dutycycle), 'h7FF);
        check({tag, "_cycle_done"}, int'(cycle_done), 0);
    endtask

    initial begin
        // Power-on reset, three cycles.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Full cycle with restart, stray start ignored, stop during the second ramp-up.
        push(0, 1'b1, 1'b0, 0);
        push_period(128, 2, 1'b0, 1'b0);
        push_period(128, 2, 1'b1, 1'b1);
        do_start(128, 2, 1'b0);
        wait_cd(400);
        repeat (10) @(negedge clk);
        step = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_drain(600, "full_cycle_stop");
        check("idle_after_stop_busy", int'(busy), 0);

        // Saturation with simultaneous start+stop: one period only.
        push(0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 22; i++) begin
            push(b_lv[i], 1'b1, 1'b0, (i == 11) ? TD * 3 : TD);
        end
        push(0, 1'b0, 1'b1, TD * 2);
        push(0, 1'b0, 1'b0, 1);
        do_start(200, 1, 1'b1);
        wait_drain(400, "saturation");

        // Stop alone in IDLE must not start anything.
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        check("stop_in_idle_busy", int'(busy), 0);

        // Mid-operation reset while in HOLD_HI.
        push(0, 1'b1, 1'b0, 0);
        for (int i = 1; i <= 16; i++) begin
            push((i == 16) ? 2047 : 128 * i, 1'b1, 1'b0, TD);
        end
        do_start(128, 2, 1'b0);
        wait_drain(200, "to_hold_hi");
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midop_reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_midop_reset");
        mon_en = 1'b1;

        // step=0 acts as 1; start+stop together gives exactly one period.
        push(0, 1'b1, 1'b0, 0);
        push_period(0, 0, 1'b1, 1'b0);
        do_start(0, 0, 1'b1);
        wait_drain(20000, "step_zero");
        check("final_busy", int'(busy), 0);
        check("final_dutycycle", int'(dutycycle), 'h7FF);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
